// File: rtl/cpu_pkg.sv
// Shared definitions for the HI/LO result stage: state encoding and default sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int CPU_WIDTH         = 32;
  localparam int CPU_SETTLE_CYCLES = 4;

endpackage

// File: rtl/reg_en.sv
// Generic enabled register with asynchronous active-high clear.
module reg_en #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hilo_result_stage.sv
// Result stage after the combinational mul/div: waits for the path to settle,
// latches ZHI/ZLO, then commits to HI/LO unless the op was a divide by zero.
module hilo_result_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH         = CPU_WIDTH,
  parameter int SETTLE_CYCLES = CPU_SETTLE_CYCLES
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   divisor_in,
  input  logic [2*WIDTH-1:0] result_in,
  input  logic [WIDTH-1:0]   bus_in,
  input  logic               hi_wr,
  input  logic               lo_wr,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   zhi_out,
  output logic [WIDTH-1:0]   zlo_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output state_t             state_dbg
);

  // Handshake: start is taken on any edge where start=1 and busy=0; while busy=1
  // start, hi_wr and lo_wr are ignored (not queued). done pulses once per accepted start.
  localparam logic [3:0] COUNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t       state;
  logic [3:0]   count;
  logic         dbz_pending;

  logic         capture;
  logic         commit_ok;
  logic         hi_en;
  logic         lo_en;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  assign capture   = (state == WAIT) && (count == 4'd0);
  assign commit_ok = (state == COMMIT) && !dbz_pending;
  // start wins over the move-to strobes in IDLE.
  assign hi_en     = commit_ok || ((state == IDLE) && !start && hi_wr);
  assign lo_en     = commit_ok || ((state == IDLE) && !start && lo_wr);
  assign hi_d      = commit_ok ? zhi_out : bus_in;
  assign lo_d      = commit_ok ? zlo_out : bus_in;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      count       <= 4'd0;
      dbz_pending <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= WAIT;
            count       <= COUNT_LOAD;
            dbz_pending <= op_div && (divisor_in == '0);
            div_by_zero <= 1'b0;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= COMMIT;
          end else begin
            count <= count - 4'd1;
          end
        end
        COMMIT: begin
          if (dbz_pending) begin
            div_by_zero <= 1'b1;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  reg_en #(.W(WIDTH)) u_zhi (
    .clock (clock), .clear (clear), .en (capture),
    .d (result_in[2*WIDTH-1:WIDTH]), .q (zhi_out)
  );

  reg_en #(.W(WIDTH)) u_zlo (
    .clock (clock), .clear (clear), .en (capture),
    .d (result_in[WIDTH-1:0]), .q (zlo_out)
  );

  reg_en #(.W(WIDTH)) u_hi (
    .clock (clock), .clear (clear), .en (hi_en),
    .d (hi_d), .q (hi_out)
  );

  reg_en #(.W(WIDTH)) u_lo (
    .clock (clock), .clear (clear), .en (lo_en),
    .d (lo_d), .q (lo_out)
  );

endmodule

// File: doc/hilo_result_stage.md
Name: hilo_result_stage

Overview:
- Sequential result stage that sits directly downstream of the combinational 32-bit multiplier/divider.
- On `start`, it waits a fixed number of cycles for the long combinational mul/div path to settle.
- It then latches the 64-bit result into ZHI/ZLO and commits it to the architectural HI/LO registers.
- It also serves mthi/mtlo writes and exposes HI/LO for mfhi/mflo. It flags divide-by-zero and suppresses that commit.

Parameters:
- WIDTH, 32, data word width; the result is 2*WIDTH wide.
- SETTLE_CYCLES, 4, number of wait cycles before capture. Legal range is 1..15; the counter is 4 bits wide.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous, active-high reset
- start  input  1  request to capture a mul/div result; honoured only in IDLE
- op_div  input  1  1=divide, 0=multiply; sampled at the start edge
- divisor_in  input  WIDTH  divisor operand; sampled at the start edge for the zero check
- result_in  input  2*WIDTH  combinational mul/div output; [63:32] goes to HI, [31:0] goes to LO
- bus_in  input  WIDTH  data for mthi/mtlo
- hi_wr  input  1  mthi strobe; honoured only in IDLE
- lo_wr  input  1  mtlo strobe; honoured only in IDLE
- busy  output  1  high in WAIT and COMMIT
- done  output  1  one-cycle pulse after a commit attempt
- div_by_zero  output  1  sticky flag, cleared by the next accepted start
- zhi_out  output  WIDTH  ZHI latch
- zlo_out  output  WIDTH  ZLO latch
- hi_out  output  WIDTH  HI register
- lo_out  output  WIDTH  LO register

Behaviour:
- Reset: `clear` is asynchronous and active-high. It forces IDLE, counter=0, and busy, done, div_by_zero, zhi_out, zlo_out, hi_out, lo_out all to 0.
  - Reset mid-operation aborts the operation with no HI/LO write.
- All outputs are registered or decoded from registered state.
- FSM states are IDLE, WAIT and COMMIT.
- IDLE:
  - If start=1 at an edge: state goes to WAIT and count is loaded with SETTLE_CYCLES-1.
  - At the same edge, dbz_pending is set to (op_div && divisor_in==0) and div_by_zero is cleared to 0.
  - start has priority over hi_wr/lo_wr in the same cycle; the strobes are dropped.
  - Otherwise hi_wr loads HI from bus_in and lo_wr loads LO from bus_in. Both may fire in the same cycle.
- WAIT:
  - Each edge decrements count.
  - The edge at which count==0 latches ZHI/ZLO from result_in and moves the state to COMMIT.
  - start, hi_wr and lo_wr are ignored.
- COMMIT edge:
  - If dbz_pending=0: HI is loaded from ZHI and LO from ZLO.
  - If dbz_pending=1: HI and LO keep their values and div_by_zero is set to 1.
  - done is set to 1 and the state returns to IDLE.
- Next edge: done goes back to 0.
- Latency for a start sampled at edge k:
  - Z is captured at edge k+SETTLE_CYCLES.
  - HI/LO are written at edge k+SETTLE_CYCLES+1.
  - done is high for the single cycle between edges k+SETTLE_CYCLES+1 and k+SETTLE_CYCLES+2.
- Back-to-back operation: a start held high continuously is accepted again at the edge after COMMIT, i.e. the first edge in IDLE.
- Operand rule: the upstream operands must stay stable from the start edge through the capture edge. The block does not check this.
- Width: no arithmetic in this block; result bits pass straight through, with no sign handling.

Decomposition:
- Shared package `cpu_pkg`:
  - state encoding enum (IDLE=2'd0, WAIT=2'd1, COMMIT=2'd2)
  - WIDTH default constant
  - SETTLE_CYCLES default constant
- Sub-module `reg_en`: one generic enabled register with async active-high clear, instanced for ZHI, ZLO, HI and LO.
- The FSM and counter are inline in `hilo_result_stage`.

Test Plan:
1. Reset mid-WAIT: start the op, assert clear 2 cycles later → all outputs 0, state IDLE, HI/LO stay 0 after release.
2. Multiply: start=1, op_div=0, result_in=64'h0000_0001_2345_6789, SETTLE_CYCLES=4 → busy for 5 cycles; zhi_out=0000_0001 at edge k+4; hi_out=0000_0001 and lo_out=2345_6789 at edge k+5; done pulses exactly 1 cycle.
3. Divide by zero:
   - Preload HI=AAAA_AAAA, LO=5555_5555 via mthi/mtlo.
   - Start with op_div=1, divisor_in=0 → HI/LO unchanged, div_by_zero=1, done pulses.
   - Next start with divisor_in=2 → div_by_zero clears at that start edge.
4. Busy lockout: during WAIT assert hi_wr with bus_in=DEAD_BEEF and a second start → HI not written, no second operation, only one done pulse.
5. mthi/mtlo:
   - IDLE, hi_wr=1 and lo_wr=1 with bus_in=1234_5678 → both HI and LO = 1234_5678 next edge.
   - Same cycle as start → strobes dropped.
6. Back-to-back: hold start high across two ops with result_in changed between them (0000_0003_0000_0001 then FFFF_FFFD_FFFF_FFFF) → second start is accepted at the first IDLE edge, and final HI/LO = FFFF_FFFD/FFFF_FFFF with two done pulses.
